// File: rtl/alu_seq_ctrl_if.sv
// Instruction-fetch handshake and ALU operand/result bus between alu_seq_ctrl,
// instruction memory and the 8-bit ALU.
interface alu_seq_ctrl_if #(
  parameter int W = 8
);
  logic         instr_req;
  logic [7:0]   instr_addr;
  logic         instr_valid;
  logic [15:0]  instr_data;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_f;
  logic         alu_c;
  logic         alu_ovf;
  logic         alu_z;
  logic         alu_n;

  modport master (
    output instr_req, instr_addr, alu_a, alu_b, alu_op,
    input  instr_valid, instr_data, alu_f, alu_c, alu_ovf, alu_z, alu_n
  );

  modport slave (
    input  instr_req, instr_addr, alu_a, alu_b, alu_op,
    output instr_valid, instr_data, alu_f, alu_c, alu_ovf, alu_z, alu_n
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer: fetches 16-bit instructions, drives the external ALU from a
// 4x8 register file, writes results back and keeps the {C,V,Z,N} branch flags.
module alu_seq_ctrl #(
  parameter int         W        = 8,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  alu_seq_ctrl_if.master      bus,
  output logic [3:0]          flags,
  output logic [7:0]          pc,
  output logic                busy,
  output logic                halted,
  output logic                err,
  input  logic [1:0]          dbg_sel,
  output logic [W-1:0]        dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [3:0][W-1:0]   regs_q, regs_d;
  logic [3:0]          flags_q, flags_d;
  logic                err_q, err_d;
  logic                req_q, req_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d;
  logic [3:0]          op_q, op_d;
  logic [W-1:0]        f_hold_q, f_hold_d;
  logic [3:0]          fl_hold_q, fl_hold_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;

  logic [1:0]          fmt_s, rd_s, rs1_s, rs2_s;
  logic [3:0]          op_s;

  // Flag word is {C,V,Z,N}; branch cond encodes 00 Z, 01 N, 10 C, 11 V.
  function automatic logic cond_flag(input logic [1:0] cond, input logic [3:0] fl);
    logic sel;
    case (cond)
      2'b00:   sel = fl[1];
      2'b01:   sel = fl[0];
      2'b10:   sel = fl[3];
      2'b11:   sel = fl[2];
      default: sel = fl[1];
    endcase
    return sel;
  endfunction

  assign fmt_s = ir_q[15:14];
  assign op_s  = ir_q[13:10];
  assign rd_s  = ir_q[9:8];
  assign rs1_s = (fmt_s == 2'b01) ? ir_q[9:8] : ir_q[7:6];
  assign rs2_s = ir_q[5:4];

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    regs_d    = regs_q;
    flags_d   = flags_q;
    err_d     = err_q;
    req_d     = req_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    f_hold_d  = f_hold_q;
    fl_hold_d = fl_hold_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (req_q && bus.instr_valid) begin
          ir_d    = bus.instr_data;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end else begin
          req_d   = 1'b1;
        end
      end
      S_DECODE: begin
        case (fmt_s)
          2'b11: state_d = S_HALT;
          2'b10: begin
            if (cond_flag(ir_q[13:12], flags_q) ^ ir_q[11]) begin
              pc_d = ir_q[7:0];
            end else begin
              pc_d = pc_q + 8'd1;
            end
            req_d   = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            // Operands are read here, so rd may alias rs1/rs2 safely.
            a_d = regs_q[rs1_s];
            if (fmt_s == 2'b01) begin
              b_d = W'(ir_q[7:0]);
            end else begin
              b_d = regs_q[rs2_s];
            end
            op_d    = op_s;
            state_d = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        f_hold_d  = bus.alu_f;
        fl_hold_d = {bus.alu_c, bus.alu_ovf, bus.alu_z, bus.alu_n};
        state_d   = S_WB;
      end
      S_WB: begin
        pc_d    = pc_q + 8'd1;
        req_d   = 1'b1;
        state_d = S_FETCH;
        if (op_s <= 4'd1) begin
          regs_d[rd_s] = f_hold_q;
          flags_d      = fl_hold_q;
        end else if (op_s <= 4'd5) begin
          regs_d[rd_s] = f_hold_q;
          flags_d      = {2'b00, fl_hold_q[1:0]};
        end else if (op_s <= 4'd10) begin
          // Shifts/rotates leave the ALU carry/overflow outputs stale.
          regs_d[rd_s] = f_hold_q;
          flags_d      = {flags_q[3:2], fl_hold_q[1:0]};
        end else begin
          err_d = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  // State, architectural registers and output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      regs_q    <= '0;
      flags_q   <= 4'b0000;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 4'b0010;
      f_hold_q  <= '0;
      fl_hold_q <= 4'b0000;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      regs_q    <= regs_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
      req_q     <= req_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      f_hold_q  <= f_hold_d;
      fl_hold_q <= fl_hold_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.instr_req  = req_q;
  assign bus.instr_addr = pc_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign flags          = flags_q;
  assign pc             = pc_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign err            = err_q;
  assign dbg_data       = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: behavioural ALU and instruction memory, with an
// expected-state scoreboard popped at each instruction retirement.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dbg_sel = 2'd0;
  logic [3:0] flags;
  logic [7:0] pc;
  logic       busy, halted, err;
  logic [7:0] dbg_data;

  int checks = 0;
  int failures = 0;

  alu_seq_ctrl_if #(.W(8)) bus ();

  alu_seq_ctrl #(.W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .flags(flags), .pc(pc), .busy(busy), .halted(halted), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  logic [7:0]  stall_addr = 8'h00;
  int          stall_cnt = 0;

  // Instruction memory: answers a request on the next edge unless a stall is armed
  always @(negedge clk) begin
    if (bus.instr_req && bus.instr_addr == stall_addr && stall_cnt > 0) begin
      stall_cnt = stall_cnt - 1;
      bus.instr_valid = 1'b0;
    end else if (bus.instr_req) begin
      bus.instr_valid = 1'b1;
      bus.instr_data  = mem[bus.instr_addr];
    end else begin
      bus.instr_valid = 1'b0;
    end
  end

  // Reference ALU; garbage C/V on logic ops, stale-looking C/V on shifts
  logic [8:0] alu_sum;
  logic [7:0] alu_res;
  always @* begin
    alu_sum = 9'd0;
    alu_res = 8'h00;
    bus.alu_c = 1'b1;
    bus.alu_ovf = 1'b1;
    case (bus.alu_op)
      4'd0: begin
        alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_res = alu_sum[7:0];
        bus.alu_c = alu_sum[8];
        bus.alu_ovf = (bus.alu_a[7] == bus.alu_b[7]) && (alu_res[7] != bus.alu_a[7]);
      end
      4'd1: begin
        alu_res = bus.alu_a - bus.alu_b;
        bus.alu_c = (bus.alu_a >= bus.alu_b);
        bus.alu_ovf = (bus.alu_a[7] != bus.alu_b[7]) && (alu_res[7] != bus.alu_a[7]);
      end
      4'd2: alu_res = 8'h00;
      4'd3: alu_res = bus.alu_a & bus.alu_b;
      4'd4: alu_res = bus.alu_a | bus.alu_b;
      4'd5: alu_res = bus.alu_a ^ bus.alu_b;
      4'd6: begin alu_res = bus.alu_a << bus.alu_b[2:0]; bus.alu_c = 1'b0; end
      4'd7: begin alu_res = bus.alu_a >> bus.alu_b[2:0]; bus.alu_c = 1'b0; end
      default: alu_res = bus.alu_a;
    endcase
    bus.alu_f = alu_res;
    bus.alu_z = (alu_res == 8'h00);
    bus.alu_n = alu_res[7];
  end

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] rval;
    logic [3:0] flg;
    logic [7:0] pcv;
    logic       errv;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] ri(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] imm);
    return {2'b01, op, rd, imm};
  endfunction
  function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
    return {2'b00, op, rd, rs1, rs2, 4'b0000};
  endfunction
  function automatic logic [15:0] br(input logic [1:0] cond, input logic inv, input logic [7:0] tgt);
    return {2'b10, cond, inv, 3'b000, tgt};
  endfunction

  task automatic put(input logic [7:0] a, input logic [15:0] w, input logic [1:0] sel,
                     input logic [7:0] rv, input logic [3:0] fl, input logic [7:0] pcv, input logic ev);
    mem[a] = w;
    sbq.push_back({sel, rv, fl, pcv, ev});
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Next 0->1 transition of instr_req marks the start of a new fetch
  task automatic wait_rise(input string tag);
    logic prev;
    logic got;
    prev = bus.instr_req;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.instr_req && !prev) got = 1'b1;
      prev = bus.instr_req;
    end
    chk($sformatf("%s_fetch_seen", tag), 32'(got), 32'd1);
  endtask

  initial begin
    exp_t e;
    logic got_halt;
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.instr_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'h2);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_fetch", 32'(bus.instr_req), 32'd0);

    // Program and expected state after each retirement: sel, reg value, {C,V,Z,N}, pc, err
    put(8'h00, ri(4'd4, 2'd0, 8'h7F), 2'd0, 8'h7F, 4'b0000, 8'h01, 1'b0);
    put(8'h01, ri(4'd0, 2'd0, 8'h01), 2'd0, 8'h80, 4'b0101, 8'h02, 1'b0);
    put(8'h02, ri(4'd4, 2'd1, 8'h05), 2'd1, 8'h05, 4'b0000, 8'h03, 1'b0);
    put(8'h03, ri(4'd1, 2'd1, 8'h05), 2'd1, 8'h00, 4'b1010, 8'h04, 1'b0);
    put(8'h04, ri(4'd6, 2'd1, 8'h01), 2'd1, 8'h00, 4'b1010, 8'h05, 1'b0);
    put(8'h05, br(2'd0, 1'b0, 8'h40), 2'd1, 8'h00, 4'b1010, 8'h40, 1'b0);
    put(8'h40, br(2'd0, 1'b1, 8'h80), 2'd1, 8'h00, 4'b1010, 8'h41, 1'b0);
    put(8'h41, ri(4'd12, 2'd0, 8'h55), 2'd0, 8'h80, 4'b1010, 8'h42, 1'b1);
    put(8'h42, rr(4'd0, 2'd2, 2'd0, 2'd1), 2'd2, 8'h80, 4'b0001, 8'h43, 1'b1);
    put(8'h43, rr(4'd0, 2'd0, 2'd0, 2'd0), 2'd0, 8'h00, 4'b1110, 8'h44, 1'b1);
    put(8'h44, br(2'd2, 1'b0, 8'hFE), 2'd0, 8'h00, 4'b1110, 8'hFE, 1'b1);
    put(8'hFE, ri(4'd4, 2'd3, 8'h0F), 2'd3, 8'h0F, 4'b0000, 8'hFF, 1'b1);
    put(8'hFF, ri(4'd4, 2'd3, 8'hF0), 2'd3, 8'hFF, 4'b0001, 8'h00, 1'b1);

    pulse_start();
    chk("start_req", 32'(bus.instr_req), 32'd1);
    chk("start_addr", 32'(bus.instr_addr), 32'h00);

    for (int i = 0; sbq.size() > 0; i++) begin
      e = sbq.pop_front();
      wait_rise($sformatf("step%0d", i));
      dbg_sel = e.sel;
      #1;
      chk($sformatf("step%0d_pc", i), 32'(pc), 32'(e.pcv));
      chk($sformatf("step%0d_addr", i), 32'(bus.instr_addr), 32'(e.pcv));
      chk($sformatf("step%0d_flags", i), 32'(flags), 32'(e.flg));
      chk($sformatf("step%0d_err", i), 32'(err), 32'(e.errv));
      chk($sformatf("step%0d_reg", i), 32'(dbg_data), 32'(e.rval));
      if (i == 0) begin
        // The wrap back to 0 will stall, then fetch a halt word
        mem[8'h00] = 16'hC000;
        stall_addr = 8'h00;
        stall_cnt  = 10;
      end
    end

    repeat (10) begin
      @(negedge clk);
      chk("stall_req", 32'(bus.instr_req), 32'd1);
      chk("stall_pc", 32'(pc), 32'h00);
      chk("stall_busy", 32'(busy), 32'd1);
    end

    got_halt = 1'b0;
    for (int n = 0; n < 20 && !got_halt; n++) begin
      @(negedge clk);
      if (halted) got_halt = 1'b1;
    end
    chk("halt_seen", 32'(got_halt), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_req", 32'(bus.instr_req), 32'd0);

    pulse_start();
    repeat (3) @(negedge clk);
    chk("halt_start_halted", 32'(halted), 32'd1);
    chk("halt_start_req", 32'(bus.instr_req), 32'd0);
    chk("halt_start_busy", 32'(busy), 32'd0);

    // Reset out of HALT clears the non-zero register file
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("rst2_flags", 32'(flags), 32'h0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_halted", 32'(halted), 32'd0);
    chk("rst2_alu_a", 32'(bus.alu_a), 32'h00);
    for (int s = 0; s < 4; s++) begin
      dbg_sel = 2'(s);
      #1;
      chk($sformatf("rst2_r%0d", s), 32'(dbg_data), 32'h00);
    end
    @(negedge clk); rst_n = 1'b1;

    // Reset asserted mid-fetch drops the request at once
    mem[8'h00] = ri(4'd4, 2'd0, 8'h7F);
    stall_addr = 8'h01;
    stall_cnt  = 50;
    pulse_start();
    wait_rise("mid");
    dbg_sel = 2'd0;
    #1;
    chk("mid_r0", 32'(dbg_data), 32'h7F);
    chk("mid_pc", 32'(pc), 32'h01);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_req", 32'(bus.instr_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'h00);
    chk("mid_rst_r0", 32'(dbg_data), 32'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_fetch", 32'(bus.instr_req), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle control unit driving the 8-bit ALU.
- Fetches 16-bit instructions over a request/valid handshake, reads operands from an internal 4x8 register file, and drives ALU operands and opcode.
- Samples the ALU result and flags, then writes back and updates a flag register used by conditional branches.
- Sits between instruction memory and the ALU in the multi-cycle CPU.

Parameters:
- W, 8, datapath width (ALU operand/result width; fixed to 8 for this ALU).
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle pulse; leaves IDLE and begins fetching at current pc.
- instr_req  output  1  fetch request, held until instr_valid.
- instr_addr  output  8  fetch address (= pc).
- instr_valid  input  1  instr_data valid; sampled only while instr_req=1.
- instr_data  input  16  instruction word.
- alu_a  output  W  ALU operand A.
- alu_b  output  W  ALU operand B.
- alu_op  output  4  ALU opcode (I).
- alu_f  input  W  ALU result.
- alu_c, alu_ovf, alu_z, alu_n  input  1 each  ALU flags.
- flags  output  4  registered {C,V,Z,N}.
- pc  output  8  program counter.
- busy  output  1  high in any state except IDLE and HALT.
- halted  output  1  high in HALT.
- err  output  1  sticky illegal-opcode flag.
- dbg_sel  input  2  register-file debug read select.
- dbg_data  output  W  combinational read of reg[dbg_sel].

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, regs r0..r3=0, flags=0, err=0, instr_req=0, alu_a=alu_b=0, alu_op=4'b0010 (clear), busy=0, halted=0.
- Instruction format:
  - [15:14]=00: reg-reg. op=[13:10], rd=[9:8], rs1=[7:6], rs2=[5:4].
  - [15:14]=01: reg-imm. op=[13:10], rd=rs1=[9:8], B=imm[7:0].
  - [15:14]=10: branch. cond=[13:12] (00 Z, 01 N, 10 C, 11 V), inv=[11], target=[7:0].
  - [15:14]=11: halt.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: start=1 -> FETCH.
- FETCH: instr_req=1, instr_addr=pc. On instr_valid=1, latch IR, deassert instr_req next cycle, go to DECODE. Wait indefinitely otherwise.
- DECODE:
  - halt -> HALT.
  - branch: taken when (flag[cond] ^ inv)=1. Taken sets pc=target; not taken sets pc=pc+1 (8-bit wrap, 8'hFF->8'h00). Then FETCH.
  - ALU op: register alu_a=reg[rs1], alu_b=reg[rs2] or imm, alu_op=op; go to EXEC.
- EXEC: one cycle with operands stable; ALU settles combinationally. At the end of EXEC, capture alu_f and the flags into holding registers. Go to WB.
- WB:
  - reg[rd]=captured F and pc=pc+1, with these exceptions:
  - Flags for op 0000/0001: C,V,Z,N all from ALU.
  - Flags for op 0010-0101: C=V=0, Z,N from ALU.
  - Flags for op 0110-1010 (shift/rotate): ALU leaves C/OVF stale, so C,V are held; Z,N from ALU.
  - Op 1011-1111 (illegal): no register write, no flag update, err<=1, pc still increments.
  - Then FETCH.
- HALT: terminal; only reset leaves it. start is ignored.
- start in any state other than IDLE is ignored.
- Per-instruction latency:
  - ALU instruction = fetch wait + 3 cycles (DECODE, EXEC, WB).
  - Branch = fetch wait + 1 cycle.
  - With instr_valid returned the cycle after request: ALU op = 5 cycles start-to-start, branch = 3.
- rd equal to rs1/rs2 is legal: operands are read in DECODE, before the WB write.
- Reset mid-operation: immediate return to reset values. A pending fetch is abandoned and instr_req drops asynchronously.

Test Plan:
- Reset/idle: assert rst_n=0 mid-FETCH. Then instr_req=0, pc=00, flags=0, busy=0, all dbg_data=00, no fetch until start.
- Reg-imm add overflow: r0 loaded 8'h7F via program; execute ADDI r0,8'h01 -> r0=8'h80, flags C=0,V=1,Z=0,N=1; pc advances by 1.
- Sub to zero and shift-hold: r1=8'h05, SUBI r1,5 -> r1=00, Z=1, C/V per ALU. Then SHL r1 by 1 -> Z=1, C,V unchanged from the prior SUB.
- Branch: after Z=1, BR cond=Z inv=0 target=8'h40 -> next instr_addr=8'h40. Same with inv=1 -> instr_addr=pc+1. Also pc=8'hFF non-branch op -> next pc=8'h00.
- Illegal opcode 4'b1100 -> destination register and flags unchanged, err=1 and stays 1, pc+1, execution continues.
- Fetch stall and halt: hold instr_valid=0 for 10 cycles -> instr_req stays 1, state frozen. Deliver halt word -> halted=1, busy=0, instr_req=0; a subsequent start pulse has no effect.
